// File: rtl/cam_pkg.sv
// Shared types for the synthetic camera pattern source.
// Pattern and FSM state encodings used by the stream top and the pixel generator.
package cam_pkg;

  typedef enum logic [1:0] {
    PAT_QUAD  = 2'd0,
    PAT_RAMP  = 2'd1,
    PAT_CHECK = 2'd2,
    PAT_FLAT  = 2'd3
  } pattern_e;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_HBLANK = 2'd2,
    S_VBLANK = 2'd3
  } state_e;

  localparam int FRAME_CNT_W = 16;
  localparam int BLANK_CNT_W = 16;

endpackage

// File: rtl/cam_pattern_gen.sv
// Combinational pixel-value function: pattern from mode and position, then
// per-channel odd-channel and global inversion.
module cam_pattern_gen
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int CHECK_LOG2 = 5,
  parameter int HW         = $clog2(IMG_WIDTH),
  parameter int VW         = $clog2(IMG_HEIGHT)
) (
  input  logic [1:0]                     mode,
  input  logic                           invert,
  input  logic [HW-1:0]                  h,
  input  logic [VW-1:0]                  v,
  input  logic [DATA_WIDTH-1:0]          flat_value,
  output logic [DATA_WIDTH*CHANNELS-1:0] pixel
);

  localparam int RW = HW + DATA_WIDTH;
  localparam logic [DATA_WIDTH-1:0] Q_TR = DATA_WIDTH'(1) << (DATA_WIDTH - 2);
  localparam logic [DATA_WIDTH-1:0] Q_BL = DATA_WIDTH'(1) << (DATA_WIDTH - 1);

  logic [RW-1:0]         ramp_num;
  logic [DATA_WIDTH-1:0] ramp_val;
  logic                  h_bit;
  logic                  v_bit;
  logic                  right;
  logic                  bottom;
  logic [DATA_WIDTH-1:0] base;

  // h < IMG_WIDTH keeps the quotient below 2^DATA_WIDTH, so the cast is lossless
  assign ramp_num = {h, {DATA_WIDTH{1'b0}}};
  assign ramp_val = DATA_WIDTH'(ramp_num / RW'(IMG_WIDTH));

  generate
    if (CHECK_LOG2 < HW) begin : g_hbit
      assign h_bit = h[CHECK_LOG2];
    end else begin : g_hzero
      assign h_bit = 1'b0;
    end
    if (CHECK_LOG2 < VW) begin : g_vbit
      assign v_bit = v[CHECK_LOG2];
    end else begin : g_vzero
      assign v_bit = 1'b0;
    end
  endgenerate

  assign right  = (h >= HW'(IMG_WIDTH / 2));
  assign bottom = (v >= VW'(IMG_HEIGHT / 2));

  always_comb begin
    base = '0;
    case (pattern_e'(mode))
      PAT_QUAD: begin
        if (!bottom) base = right ? Q_TR : '0;
        else         base = right ? '1 : Q_BL;
      end
      PAT_RAMP:  base = ramp_val;
      PAT_CHECK: base = (h_bit ^ v_bit) ? '1 : '0;
      PAT_FLAT:  base = flat_value;
      default:   base = '0;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
      assign pixel[gi*DATA_WIDTH +: DATA_WIDTH] =
        base ^ {DATA_WIDTH{invert ^ ((gi % 2) == 1)}};
    end
  endgenerate

endmodule

// File: rtl/cam_pattern_stream.sv
// Synthetic camera source: frame/line FSM with blanking and backpressure,
// emitting generated pixels as a valid/ready stream.
module cam_pattern_stream
  import cam_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int DATA_WIDTH = 8,
  parameter int CHANNELS   = 1,
  parameter int H_BLANK    = 0,
  parameter int V_BLANK    = 0,
  parameter int CHECK_LOG2 = 5
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           enable,
  input  logic [1:0]                     mode,
  input  logic                           invert,
  output logic [DATA_WIDTH*CHANNELS-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic                           m_tuser,
  output logic                           m_tlast,
  output logic [$clog2(IMG_WIDTH)-1:0]   hcount,
  output logic [$clog2(IMG_HEIGHT)-1:0]  vcount,
  output logic [FRAME_CNT_W-1:0]         frame_count,
  output logic                           busy
);

  localparam int HW = $clog2(IMG_WIDTH);
  localparam int VW = $clog2(IMG_HEIGHT);

  state_e                   state_reg, state_next;
  logic [HW-1:0]            h_reg, h_next;
  logic [VW-1:0]            v_reg, v_next;
  logic [FRAME_CNT_W-1:0]   fc_reg, fc_next;
  logic [BLANK_CNT_W-1:0]   blank_reg, blank_next;
  logic [1:0]               mode_reg, mode_next;
  logic                     invert_reg, invert_next;
  logic                     start_frame;
  logic                     last_pix;
  logic                     last_line;
  logic [DATA_WIDTH*CHANNELS-1:0] pixel;

  assign last_pix  = (h_reg == HW'(IMG_WIDTH - 1));
  assign last_line = (v_reg == VW'(IMG_HEIGHT - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      h_reg      <= '0;
      v_reg      <= '0;
      fc_reg     <= '0;
      blank_reg  <= '0;
      mode_reg   <= '0;
      invert_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      h_reg      <= h_next;
      v_reg      <= v_next;
      fc_reg     <= fc_next;
      blank_reg  <= blank_next;
      mode_reg   <= mode_next;
      invert_reg <= invert_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    h_next      = h_reg;
    v_next      = v_reg;
    fc_next     = fc_reg;
    blank_next  = blank_reg;
    mode_next   = mode_reg;
    invert_next = invert_reg;
    start_frame = 1'b0;

    case (state_reg)
      S_IDLE: begin
        if (enable) begin
          state_next  = S_ACTIVE;
          start_frame = 1'b1;
        end
      end
      S_ACTIVE: begin
        if (m_tready) begin
          if (!last_pix) begin
            h_next = h_reg + 1'b1;
          end else begin
            h_next = '0;
            v_next = last_line ? '0 : v_reg + 1'b1;
            if (last_line) fc_next = fc_reg + 1'b1;
            if (H_BLANK > 0) begin
              state_next = S_HBLANK;
              blank_next = '0;
            end else if (last_line) begin
              if (V_BLANK > 0) begin
                state_next = S_VBLANK;
                blank_next = '0;
              end else begin
                state_next  = enable ? S_ACTIVE : S_IDLE;
                start_frame = enable;
              end
            end
          end
        end
      end
      S_HBLANK: begin
        // v has already wrapped, so v==0 here means the frame's last line just ended
        if (blank_reg == BLANK_CNT_W'(H_BLANK - 1)) begin
          blank_next = '0;
          if (v_reg != '0) begin
            state_next = S_ACTIVE;
          end else if (V_BLANK > 0) begin
            state_next = S_VBLANK;
          end else begin
            state_next  = enable ? S_ACTIVE : S_IDLE;
            start_frame = enable;
          end
        end else begin
          blank_next = blank_reg + 1'b1;
        end
      end
      S_VBLANK: begin
        if (blank_reg == BLANK_CNT_W'(V_BLANK - 1)) begin
          blank_next  = '0;
          state_next  = enable ? S_ACTIVE : S_IDLE;
          start_frame = enable;
        end else begin
          blank_next = blank_reg + 1'b1;
        end
      end
      default: state_next = S_IDLE;
    endcase

    if (start_frame) begin
      h_next      = '0;
      v_next      = '0;
      mode_next   = mode;
      invert_next = invert;
    end
  end

  cam_pattern_gen #(
    .IMG_WIDTH (IMG_WIDTH),
    .IMG_HEIGHT(IMG_HEIGHT),
    .DATA_WIDTH(DATA_WIDTH),
    .CHANNELS  (CHANNELS),
    .CHECK_LOG2(CHECK_LOG2)
  ) u_gen (
    .mode      (mode_reg),
    .invert    (invert_reg),
    .h         (h_reg),
    .v         (v_reg),
    .flat_value(DATA_WIDTH'(fc_reg)),
    .pixel     (pixel)
  );

  assign m_tvalid    = (state_reg == S_ACTIVE);
  assign m_tuser     = m_tvalid && (h_reg == '0) && (v_reg == '0);
  assign m_tlast     = m_tvalid && last_pix;
  assign m_tdata     = m_tvalid ? pixel : '0;
  assign hcount      = h_reg;
  assign vcount      = v_reg;
  assign frame_count = fc_reg;
  assign busy        = (state_reg != S_IDLE);

endmodule

// File: tb/tb_cam_pattern_stream.sv
// Bench for cam_pattern_stream: two 8x4 instances (no blanking / 2 channels,
// and H_BLANK=3 V_BLANK=5 / 1 channel) checked against an arithmetic pixel model.
module tb_cam_pattern_stream;

  typedef struct {
    logic [15:0] d;
    logic        v;
    logic        u;
    logic        l;
    logic        b;
    logic [2:0]  h;
    logic [1:0]  vv;
    logic [15:0] f;
  } obs_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        en  [2];
  logic [1:0]  md  [2];
  logic        inv [2];
  logic        rdy [2];
  logic [15:0] td0;
  logic [7:0]  td1;
  logic        tv  [2];
  logic        tu  [2];
  logic        tl  [2];
  logic        bz  [2];
  logic [2:0]  hc  [2];
  logic [1:0]  vc  [2];
  logic [15:0] fc  [2];

  int errors = 0;
  int checks = 0;
  int exp_fc [2];

  obs_t cap[$];
  int   cap_cyc[$];
  int   stall_bad;
  bit   cap_timeout;
  int   first_valid_cyc;

  always #5 clk = ~clk;

  cam_pattern_stream #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .DATA_WIDTH(8), .CHANNELS(2),
    .H_BLANK(0), .V_BLANK(0), .CHECK_LOG2(1)
  ) dut0 (
    .clk(clk), .rst(rst), .enable(en[0]), .mode(md[0]), .invert(inv[0]),
    .m_tdata(td0), .m_tvalid(tv[0]), .m_tready(rdy[0]), .m_tuser(tu[0]),
    .m_tlast(tl[0]), .hcount(hc[0]), .vcount(vc[0]), .frame_count(fc[0]),
    .busy(bz[0])
  );

  cam_pattern_stream #(
    .IMG_WIDTH(8), .IMG_HEIGHT(4), .DATA_WIDTH(8), .CHANNELS(1),
    .H_BLANK(3), .V_BLANK(5), .CHECK_LOG2(1)
  ) dut1 (
    .clk(clk), .rst(rst), .enable(en[1]), .mode(md[1]), .invert(inv[1]),
    .m_tdata(td1), .m_tvalid(tv[1]), .m_tready(rdy[1]), .m_tuser(tu[1]),
    .m_tlast(tl[1]), .hcount(hc[1]), .vcount(vc[1]), .frame_count(fc[1]),
    .busy(bz[1])
  );

  // Pixel model from the pattern definitions, for an 8x4 image, 8-bit channels, 2x2 squares
  function automatic logic [7:0] ref_pix(int m, int h, int v, int f, int n, int c);
    int p;
    case (m)
      0:       p = (h < 4) ? ((v < 2) ? 0 : 128) : ((v < 2) ? 64 : 255);
      1:       p = (h * 256) / 8;
      2:       p = (((h / 2) + (v / 2)) % 2 == 1) ? 255 : 0;
      default: p = f % 256;
    endcase
    if (c % 2 == 1) p = p ^ 255;
    if (n != 0)     p = p ^ 255;
    return p[7:0];
  endfunction

  function automatic logic [22:0] exp_word(int w, int m, int n, int f, int i);
    int eh = i % 8;
    int ev = (i / 8) % 4;
    logic [15:0] ed;
    ed[7:0]  = ref_pix(m, eh, ev, f, n, 0);
    ed[15:8] = (w == 0) ? ref_pix(m, eh, ev, f, n, 1) : 8'h00;
    return {ed, 1'(eh == 0 && ev == 0), 1'(eh == 7), 3'(eh), 2'(ev)};
  endfunction

  function automatic logic [22:0] act_word(obs_t o);
    return {o.d, o.u, o.l, o.h, o.vv};
  endfunction

  function automatic obs_t snap(int w);
    obs_t o;
    if (w == 0) begin
      o.d = td0;
    end else begin
      o.d = {8'h00, td1};
    end
    o.v = tv[w]; o.u = tu[w]; o.l = tl[w]; o.b = bz[w];
    o.h = hc[w]; o.vv = vc[w]; o.f = fc[w];
    return o;
  endfunction

  // Drives ready and records every handshaked beat; after beat number drop_at
  // it drops enable and scrambles mode/invert to prove they were latched.
  task automatic capture(input int w, input int nbeats, input int drop_at, input bit rnd);
    obs_t o;
    obs_t held;
    bit   stalled = 1'b0;
    int   cyc = 0;
    int   got = 0;
    cap.delete();
    cap_cyc.delete();
    stall_bad = 0;
    cap_timeout = 1'b0;
    first_valid_cyc = -1;
    while (got < nbeats) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc > 3000) begin
        cap_timeout = 1'b1;
        break;
      end
      o = snap(w);
      if (o.v && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (stalled && (o.v !== 1'b1 || o.d !== held.d || o.u !== held.u ||
                      o.l !== held.l || o.h !== held.h || o.vv !== held.vv))
        stall_bad++;
      rdy[w] = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (o.v && rdy[w]) begin
        cap.push_back(o);
        cap_cyc.push_back(cyc);
        got++;
        if (got == drop_at) begin
          en[w]  = 1'b0;
          md[w]  = 2'(md[w] + 2'd1);
          inv[w] = ~inv[w];
        end
      end
      stalled = o.v && !rdy[w];
      held = o;
    end
  endtask

  task automatic wait_idle(input int w, output bit ok);
    ok = 1'b0;
    rdy[w] = 1'b1;
    for (int k = 0; k < 200; k++) begin
      @(posedge clk); #1;
      if (!bz[w]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    for (int w = 0; w < 2; w++) begin
      checks++;
      if ({tv[w], tu[w], tl[w], bz[w]} !== 4'b0000) begin
        errors++;
        $display("FAIL reset_flags dut%0d: got %b expected 0000", w, {tv[w], tu[w], tl[w], bz[w]});
      end
      checks++;
      if (hc[w] !== 3'd0 || vc[w] !== 2'd0) begin
        errors++;
        $display("FAIL reset_counters dut%0d: got h=%0d v=%0d expected 0", w, hc[w], vc[w]);
      end
      checks++;
      if (fc[w] !== 16'd0) begin
        errors++;
        $display("FAIL reset_frame_count dut%0d: got %0d expected 0", w, fc[w]);
      end
    end
    checks++;
    if (td0 !== 16'h0 || td1 !== 8'h0) begin
      errors++;
      $display("FAIL reset_tdata: got %h/%h expected 0", td0, td1);
    end
    $display("test_reset done");
  endtask

  task automatic test_pattern_frame(input string name, input int m, input int n, input bit rnd);
    bit ok;
    md[0] = 2'(m); inv[0] = n[0]; en[0] = 1'b1;
    capture(0, 32, 1, rnd);
    checks++;
    if (cap_timeout) begin
      errors++;
      $display("FAIL %s_timeout: got %0d beats expected 32", name, cap.size());
    end
    checks++;
    if (first_valid_cyc != 1) begin
      errors++;
      $display("FAIL %s_start_latency: got %0d expected 1", name, first_valid_cyc);
    end
    for (int i = 0; i < cap.size(); i++) begin
      checks++;
      if (act_word(cap[i]) !== exp_word(0, m, n, exp_fc[0], i)) begin
        errors++;
        $display("FAIL %s_beat %0d: got %h expected %h", name, i,
                 act_word(cap[i]), exp_word(0, m, n, exp_fc[0], i));
      end
    end
    if (rnd) begin
      checks++;
      if (stall_bad != 0) begin
        errors++;
        $display("FAIL %s_stall_hold: got %0d unstable stalls expected 0", name, stall_bad);
      end
    end
    wait_idle(0, ok);
    exp_fc[0]++;
    checks++;
    if (!ok || fc[0] !== 16'(exp_fc[0])) begin
      errors++;
      $display("FAIL %s_frame_end: got idle=%0d fc=%0d expected idle=1 fc=%0d", name, ok, fc[0], exp_fc[0]);
    end
    $display("%s: mode=%0d invert=%0d beats=%0d", name, m, n, cap.size());
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++)
      test_pattern_frame("random", int'($urandom_range(0, 3)), int'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic test_blanking();
    bit ok;
    int gap;
    md[1] = 2'd0; inv[1] = 1'b0; en[1] = 1'b1;
    capture(1, 64, 33, 1'b0);
    checks++;
    if (cap_timeout || first_valid_cyc != 1) begin
      errors++;
      $display("FAIL blank_start: got beats=%0d first=%0d expected 64 and 1", cap.size(), first_valid_cyc);
    end
    for (int i = 0; i < cap.size(); i++) begin
      checks++;
      if (act_word(cap[i]) !== exp_word(1, 0, 0, exp_fc[1] + i / 32, i)) begin
        errors++;
        $display("FAIL blank_beat %0d: got %h expected %h", i, act_word(cap[i]),
                 exp_word(1, 0, 0, exp_fc[1] + i / 32, i));
      end
      if (i > 0) begin
        gap = (i % 32 == 0) ? 9 : ((i % 8 == 0) ? 4 : 1);
        checks++;
        if (cap_cyc[i] - cap_cyc[i-1] != gap) begin
          errors++;
          $display("FAIL blank_gap %0d: got %0d cycles expected %0d", i, cap_cyc[i] - cap_cyc[i-1], gap);
        end
      end
    end
    wait_idle(1, ok);
    exp_fc[1] += 2;
    checks++;
    if (!ok || fc[1] !== 16'(exp_fc[1])) begin
      errors++;
      $display("FAIL blank_frame_end: got idle=%0d fc=%0d expected idle=1 fc=%0d", ok, fc[1], exp_fc[1]);
    end
    $display("test_blanking: beats=%0d", cap.size());
  endtask

  task automatic test_mid_frame_change();
    test_pattern_frame("midframe", 2, 0, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      checks++;
      if (tv[0] !== 1'b0 || bz[0] !== 1'b0) begin
        errors++;
        $display("FAIL midframe_idle: got valid=%b busy=%b expected 0 0", tv[0], bz[0]);
      end
    end
    // capture left mode=3, invert=1 behind; re-enabling must pick those up
    test_pattern_frame("reenable", int'(md[0]), int'(inv[0]), 1'b0);
  endtask

  task automatic test_reset_mid_frame();
    bit ok;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_fc[0] = 0;
    exp_fc[1] = 0;
    md[0] = 2'd0; inv[0] = 1'b0; en[0] = 1'b1;
    capture(0, 13, 99, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({tv[0], tu[0], tl[0], bz[0]} !== 4'b0000 || td0 !== 16'h0) begin
      errors++;
      $display("FAIL rst_mid_flags: got %b data=%h expected 0000 data=0", {tv[0], tu[0], tl[0], bz[0]}, td0);
    end
    checks++;
    if (hc[0] !== 3'd0 || vc[0] !== 2'd0 || fc[0] !== 16'd0) begin
      errors++;
      $display("FAIL rst_mid_counters: got h=%0d v=%0d fc=%0d expected 0 0 0", hc[0], vc[0], fc[0]);
    end
    rst = 1'b0;
    capture(0, 32, 1, 1'b0);
    checks++;
    if (cap_timeout || first_valid_cyc != 1 || cap[0].u !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_restart: got beats=%0d first=%0d expected 32 and 1 with tuser",
               cap.size(), first_valid_cyc);
    end
    for (int i = 0; i < cap.size(); i++) begin
      checks++;
      if (act_word(cap[i]) !== exp_word(0, 0, 0, 0, i)) begin
        errors++;
        $display("FAIL rst_mid_beat %0d: got %h expected %h", i, act_word(cap[i]), exp_word(0, 0, 0, 0, i));
      end
    end
    wait_idle(0, ok);
    exp_fc[0] = 1;
    checks++;
    if (!ok || fc[0] !== 16'd1) begin
      errors++;
      $display("FAIL rst_mid_frame_end: got idle=%0d fc=%0d expected idle=1 fc=1", ok, fc[0]);
    end
    $display("test_reset_mid_frame: restart beats=%0d", cap.size());
  endtask

  initial begin
    rst = 1'b1;
    for (int w = 0; w < 2; w++) begin
      en[w] = 1'b0; md[w] = 2'd0; inv[w] = 1'b0; rdy[w] = 1'b1;
    end
    test_reset();
    test_pattern_frame("quad", 0, 0, 1'b0);
    test_pattern_frame("backpressure", 0, 0, 1'b1);
    test_pattern_frame("ramp", 1, 0, 1'b0);
    test_pattern_frame("checker", 2, 0, 1'b0);
    test_pattern_frame("flat_invert", 3, 1, 1'b0);
    test_pattern_frame("checker_invert", 2, 1, 1'b1);
    test_random();
    test_blanking();
    test_mid_frame_change();
    test_reset_mid_frame();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation still running after time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
